// File: rtl/alu_seq_ctrl.sv
// Sequential ALU: decodes {aluop, funct}, finishes simple ops in one cycle and
// runs shift-add multiply / restoring divide over N cycles behind valid/ready handshakes.
module alu_seq_ctrl #(
  parameter int N       = 32,
  parameter int FUNCT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       a,
  input  logic [N-1:0]       b,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       result,
  output logic               zero,
  output logic               illegal,
  output logic               busy
);

  localparam int CW  = $clog2(N) + 1;
  localparam int SHW = $clog2(N);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
    OP_DIVU, OP_REMU, OP_SLL, OP_SRL, OP_ILL
  } op_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  acc_q, acc_d;   // product accumulator / partial remainder
  logic [N-1:0]  opa_q, opa_d;   // multiplicand / dividend shifting into quotient
  logic [N-1:0]  opb_q, opb_d;   // multiplier / divisor
  logic          is_rem_q, is_rem_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  result_q, result_d;
  logic          zero_q, zero_d;
  logic          illegal_q, illegal_d;

  op_e          op;
  logic [N-1:0] sc_res;
  logic         accept;
  logic         load, load_ill;
  logic [N-1:0] load_val;
  logic [N-1:0] mul_acc;
  logic [N:0]   rem_sh, rem_diff;
  logic         q_bit;
  logic [N-1:0] div_rem, div_quot;

  assign in_ready  = reset && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = OP_ILL;
    case (aluop)
      2'b11: op = OP_ADD;
      2'b10: op = OP_SUB;
      2'b01: op = OP_SLT;
      default: begin
        case (funct)
          FUNCT_W'(0): op = OP_ADD;
          FUNCT_W'(1): op = OP_SUB;
          FUNCT_W'(2): op = OP_AND;
          FUNCT_W'(3): op = OP_OR;
          FUNCT_W'(4): op = OP_SLT;
          FUNCT_W'(5): op = OP_MUL;
          FUNCT_W'(6): op = OP_DIVU;
          FUNCT_W'(7): op = OP_REMU;
          FUNCT_W'(8): op = OP_SLL;
          FUNCT_W'(9): op = OP_SRL;
          default:     op = OP_ILL;
        endcase
      end
    endcase
  end

  // Divide ops only reach this path when b is zero.
  always_comb begin
    sc_res = '0;
    case (op)
      OP_ADD:  sc_res = a + b;
      OP_SUB:  sc_res = a - b;
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_SLT:  sc_res = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  sc_res = a << b[SHW-1:0];
      OP_SRL:  sc_res = a >> b[SHW-1:0];
      OP_DIVU: sc_res = '1;
      OP_REMU: sc_res = a;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    mul_acc  = opb_q[0] ? (acc_q + opa_q) : acc_q;
    rem_sh   = {acc_q, opa_q[N-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    q_bit    = !rem_diff[N];    // no borrow: shifted remainder >= divisor
    div_rem  = q_bit ? rem_diff[N-1:0] : rem_sh[N-1:0];
    div_quot = {opa_q[N-2:0], q_bit};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    is_rem_d    = is_rem_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    load        = 1'b0;
    load_val    = '0;
    load_ill    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d    = '0;
          opa_d    = a;
          opb_d    = b;
          cnt_d    = '0;
          is_rem_d = (op == OP_REMU);
          if (op == OP_MUL) begin
            state_d = S_MUL;
          end else if ((op == OP_DIVU || op == OP_REMU) && b != '0) begin
            state_d = S_DIV;
          end else begin
            load     = 1'b1;
            load_val = sc_res;
            load_ill = (op == OP_ILL);
          end
        end
      end
      S_MUL: begin
        acc_d = mul_acc;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          load     = 1'b1;
          load_val = mul_acc;
        end
      end
      S_DIV: begin
        acc_d = div_rem;
        opa_d = div_quot;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          load     = 1'b1;
          load_val = is_rem_q ? div_rem : div_quot;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      result_d    = load_val;
      zero_d      = (load_val == '0);
      illegal_d   = load_ill;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      is_rem_q    <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      is_rem_q    <= is_rem_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases, random ops against an
// arithmetic reference model, backpressure, throughput scoreboard and mid-op reset.
module tb_alu_seq_ctrl;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a, b;
  logic [1:0]    aluop;
  logic [3:0]    funct;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  result;
  logic          zero;
  logic          illegal;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_r;
  logic        exp_ill;
  int          exp_lat;
  int          popped;
  logic [1:0]  r_op;
  logic [3:0]  r_f;
  logic [31:0] r_a, r_b;
  logic [3:0]  sc_funct[7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

  alu_seq_ctrl #(.N(N), .FUNCT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .aluop     (aluop),
    .funct     (funct),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: result, illegal flag and accept-to-valid latency.
  function automatic void model(input logic [1:0] op, input logic [3:0] f,
                                input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [63:0] p;
    p   = {32'd0, x} * {32'd0, y};
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      2'b11: r = x + y;
      2'b10: r = x - y;
      2'b01: r = {31'd0, ($signed(x) < $signed(y))};
      default: begin
        case (f)
          4'd0: r = x + y;
          4'd1: r = x - y;
          4'd2: r = x & y;
          4'd3: r = x | y;
          4'd4: r = {31'd0, ($signed(x) < $signed(y))};
          4'd5: begin r = p[31:0]; lat = N + 1; end
          4'd6: if (y == 0) r = 32'hFFFF_FFFF; else begin r = x / y; lat = N + 1; end
          4'd7: if (y == 0) r = x; else begin r = x % y; lat = N + 1; end
          4'd8: r = x << y[4:0];
          4'd9: r = x >> y[4:0];
          default: ill = 1'b1;
        endcase
      end
    endcase
  endfunction

  // Issue one op with out_ready=1, wait for its result, check value, flags,
  // latency and the busy/in_ready behaviour while it runs.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [3:0] f,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic        eill;
    int          elat;
    int          lat;
    int          waits;
    int          bad;
    model(op, f, x, y, er, eill, elat);
    waits = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    aluop    = op;
    funct    = f;
    a        = x;
    b        = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    bad = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(elat));
    check({tag, "_busy_wait"}, 32'(bad), 32'd0);
    check({tag, "_res"}, result, er);
    check({tag, "_zero"}, 32'(zero), 32'(er == 32'd0));
    check({tag, "_ill"}, 32'(illegal), 32'(eill));
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    aluop     = 2'b00;
    funct     = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed single-cycle cases
    run_op("add", 2'b00, 4'd0, 32'd5, 32'd7);
    run_op("sub", 2'b00, 4'd1, 32'hFFFF_FFF0, 32'h10);
    run_op("slt", 2'b00, 4'd4, 32'hFFFF_FFF0, 32'h10);
    run_op("beq", 2'b10, 4'd0, 32'd9, 32'd9);
    run_op("sll", 2'b00, 4'd8, 32'hFFFF_FFF0, 32'd4);
    run_op("srl", 2'b00, 4'd9, 32'hFFFF_FFF0, 32'd36);
    run_op("ill", 2'b00, 4'd15, 32'h1234, 32'h5678);
    run_op("addi", 2'b11, 4'd15, 32'hFFFF_FFFF, 32'd1);
    run_op("slti", 2'b01, 4'd9, 32'd3, 32'hFFFF_FFFF);

    // Multiply and divide
    run_op("mul1", 2'b00, 4'd5, 32'h0001_0003, 32'h0000_0005);
    run_op("mul2", 2'b00, 4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("divu", 2'b00, 4'd6, 32'd100, 32'd7);
    run_op("remu", 2'b00, 4'd7, 32'd100, 32'd7);
    run_op("divu0", 2'b00, 4'd6, 32'd100, 32'd0);
    run_op("remu0", 2'b00, 4'd7, 32'd100, 32'd0);
    run_op("divbig", 2'b00, 4'd6, 32'hFFFF_FFFF, 32'h8000_0001);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_f  = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 40));
        default: r_b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), r_op, r_f, r_a, r_b);
    end

    // Backpressure: result must hold while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    aluop     = 2'b00;
    funct     = 4'd0;
    a         = 32'h11;
    b         = 32'h22;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_res%0d", i), result, 32'h33);
      check($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_drop", 32'(out_valid), 32'd0);

    // Throughput: one single-cycle op per cycle, scoreboarded
    popped = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        check("tput_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check($sformatf("tput_res%0d", popped), result, exp_q.pop_front());
          popped++;
        end
      end else if (i > 0) begin
        check($sformatf("tput_gap%0d", i), 32'(out_valid), 32'd1);
      end
      check($sformatf("tput_ready%0d", i), 32'(in_ready), 32'd1);
      r_op = 2'($urandom_range(0, 3));
      r_f  = sc_funct[$urandom_range(0, 6)];
      r_a  = $urandom;
      r_b  = $urandom;
      model(r_op, r_f, r_a, r_b, exp_r, exp_ill, exp_lat);
      exp_q.push_back(exp_r);
      in_valid = 1'b1;
      aluop    = r_op;
      funct    = r_f;
      a        = r_a;
      b        = r_b;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      check($sformatf("tput_res%0d", popped), result, exp_q.pop_front());
      popped++;
    end
    @(negedge clk);
    check("tput_count", 32'(popped), 32'd20);
    check("tput_left", 32'(exp_q.size()), 32'd0);
    check("tput_idle", 32'(out_valid), 32'd0);

    // Reset during a divide
    @(negedge clk);
    in_valid = 1'b1;
    aluop    = 2'b00;
    funct    = 4'd6;
    a        = 32'd1000;
    b        = 32'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_result", result, 32'd0);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    run_op("post_mul", 2'b00, 4'd5, 32'd3, 32'd4);
    @(negedge clk);
    check("post_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
